wm8731_init_sequencer: RTL and testbench

// - Sequences the codec I2C writer (I2C_AUD) through a fixed WM8731 power-up register table.
// - Presents one 3-byte write per entry: device address, {reg[6:0],d[8]}, d[7:0].
// - Pulses the writer's START, waits for its DONE, then idles a gap before the next entry.
// - Sits between top-level reset/boot logic and I2C_AUD; asserts init_done once the table is written.

---
 rtl/wm8731_init_sequencer.sv | 139 +++++++++++++
 tb/tb_wm8731_init_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_init_sequencer.sv
// Walks the WM8731 power-up register table and feeds one 3-byte write per entry to the
// I2C_AUD writer, pacing each entry by START/DONE and a fixed idle gap.
module wm8731_init_sequencer #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         GAP_CYCLES  = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       init_req,
    input  logic       i2c_done,
    output logic       i2c_start,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_data1,
    output logic [7:0] i2c_data2,
    output logic [3:0] reg_idx,
    output logic       busy,
    output logic       init_done,
    output logic       fault,
    output logic [2:0] fsm_state
);

    localparam int NUM_REGS = 11;
    localparam int TCW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST     = GCW'(GAP_CYCLES - 1);
    localparam logic [3:0]     IDX_LAST     = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t           state;
    logic             done_q;
    logic             done_rise;
    logic [TCW-1:0]   timeout_cnt;
    logic [GCW-1:0]   gap_cnt;

    // Each entry packs {reg[6:0], d[8:0]}, which is exactly {data1, data2}.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'd15, 9'h000};
            4'd1:    table_entry = {7'd6,  9'h000};
            4'd2:    table_entry = {7'd0,  9'h017};
            4'd3:    table_entry = {7'd1,  9'h017};
            4'd4:    table_entry = {7'd2,  9'h079};
            4'd5:    table_entry = {7'd3,  9'h079};
            4'd6:    table_entry = {7'd4,  9'h012};
            4'd7:    table_entry = {7'd5,  9'h000};
            4'd8:    table_entry = {7'd7,  9'h002};
            4'd9:    table_entry = {7'd8,  9'h000};
            4'd10:   table_entry = {7'd9,  9'h001};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    // Handshake with I2C_AUD: i2c_start is a one-cycle request with addr/data already stable;
    // the writer acknowledges with a rising edge on i2c_done, and only the edge is consumed.
    assign done_rise = i2c_done & ~done_q;
    assign fsm_state = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            done_q      <= 1'b0;
            i2c_start   <= 1'b0;
            i2c_addr    <= 8'h00;
            i2c_data1   <= 8'h00;
            i2c_data2   <= 8'h00;
            reg_idx     <= 4'd0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            fault       <= 1'b0;
            timeout_cnt <= '0;
            gap_cnt     <= '0;
        end else begin
            done_q    <= i2c_done;
            i2c_start <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    if (init_req) begin
                        state     <= ST_LOAD;
                        reg_idx   <= 4'd0;
                        init_done <= 1'b0;
                        fault     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    i2c_addr                 <= DEV_ADDR;
                    {i2c_data1, i2c_data2}   <= table_entry(reg_idx);
                    i2c_start                <= 1'b1;
                    state                    <= ST_START;
                end
                ST_START: begin
                    timeout_cnt <= '0;
                    state       <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A DONE edge takes priority over a timeout landing in the same cycle.
                    if (done_rise) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FAULT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (reg_idx == IDX_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            reg_idx <= reg_idx + 4'd1;
                            state   <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_init_sequencer.sv
// Randomized scoreboard bench for wm8731_init_sequencer: a table-driven reference model predicts
// each START (fields and cycle), a monitor pops and compares whenever START is seen.
module tb_wm8731_init_sequencer;

    localparam int GAP     = 16;
    localparam int TMO     = 100;
    localparam int NREG    = 11;
    localparam int W       = 60;
    localparam logic [7:0] DEV = 8'h34;

    logic       Clk;
    logic       Reset;
    logic       init_req;
    logic       i2c_done;
    logic       i2c_start;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_data1;
    logic [7:0] i2c_data2;
    logic [3:0] reg_idx;
    logic       busy;
    logic       init_done;
    logic       fault;
    logic [2:0] fsm_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];

    int reg_num [NREG] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
    int reg_val [NREG] = '{'h000, 'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h002, 'h000, 'h001};

    wm8731_init_sequencer #(
        .DEV_ADDR    (DEV),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .init_req  (init_req),
        .i2c_done  (i2c_done),
        .i2c_start (i2c_start),
        .i2c_addr  (i2c_addr),
        .i2c_data1 (i2c_data1),
        .i2c_data2 (i2c_data2),
        .reg_idx   (reg_idx),
        .busy      (busy),
        .init_done (init_done),
        .fault     (fault),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model / checker ----------------
    function automatic logic [W-1:0] exp_word(input int idx, input int at_cyc);
        int d1;
        int d2;
        d1 = reg_num[idx] * 2 + reg_val[idx] / 256;
        d2 = reg_val[idx] % 256;
        return {32'(at_cyc), DEV, 8'(d1), 8'(d2), 4'(idx)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic         prev_start;
        logic [W-1:0] e;
        prev_start = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_start = 1'b0;
            end else begin
                if (i2c_start) begin
                    check("start_width", 64'(prev_start), 64'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_start_idx", 64'(reg_idx), 64'(16));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("start_fields_e%0d", e[3:0]),
                              64'({i2c_addr, i2c_data1, i2c_data2, reg_idx}), 64'(e[27:0]));
                        check($sformatf("start_cycle_e%0d", e[3:0]), 64'(cyc), 64'(e[59:28]));
                        check("busy_at_start", 64'(busy), 64'(1));
                    end
                end
                prev_start = i2c_start;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_init();
        @(negedge Clk);
        init_req = 1'b1;
        exp_q.push_back(exp_word(0, cyc + 2));
        @(negedge Clk);
        init_req = 1'b0;
        check("busy_after_req", 64'(busy), 64'(1));
        check("init_done_cleared", 64'(init_done), 64'(0));
        check("fault_cleared", 64'(fault), 64'(0));
    endtask

    task automatic wait_start(output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (i2c_start === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic respond(input int idx, input int dly, input int len, input bit poke, output int dc);
        for (int i = 0; i < dly; i++) begin
            @(negedge Clk);
            if (poke) init_req = (i == 0);
        end
        init_req = 1'b0;
        i2c_done = 1'b1;
        dc = cyc;
        if (idx < NREG - 1) exp_q.push_back(exp_word(idx + 1, cyc + GAP + 2));
        repeat (len) @(negedge Clk);
        i2c_done = 1'b0;
    endtask

    task automatic run_seq(input int stop_idx, input bit rand_timing, input bit poke_at2,
                           output int stop_cyc);
        int c;
        bit ok;
        int dly;
        int len;
        int dc;
        int dn_cyc;
        stop_cyc = -1;
        dc       = 0;
        for (int idx = 0; idx < NREG; idx++) begin
            wait_start(c, ok);
            check($sformatf("start_seen_e%0d", idx), 64'(ok), 64'(1));
            if (!ok) return;
            if (idx == stop_idx) begin
                stop_cyc = c;
                return;
            end
            dly = rand_timing ? int'($urandom_range(2, 40)) : 20;
            len = rand_timing ? int'($urandom_range(1, 5)) : 5;
            respond(idx, dly, len, poke_at2 && (idx == 2), dc);
        end
        dn_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (init_done === 1'b1) begin
                dn_cyc = cyc;
                break;
            end
            @(negedge Clk);
        end
        check("init_done_cycle", 64'(dn_cyc), 64'(dc + GAP + 1));
        check("busy_when_done", 64'(busy), 64'(0));
        check("reg_idx_when_done", 64'(reg_idx), 64'(NREG - 1));
        check("fault_when_done", 64'(fault), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int fc;
        bit seen;
        Reset    = 1'b1;
        init_req = 1'b0;
        i2c_done = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_start", 64'(i2c_start), 64'(0));
        check("rst_fields", 64'({i2c_addr, i2c_data1, i2c_data2, reg_idx}), 64'(0));
        check("rst_flags", 64'({busy, init_done, fault}), 64'(0));
        $display("info: state code after reset %0d", fsm_state);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Fixed timing: DONE 20 cycles after START, held as a 5-cycle level.
        pulse_init();
        run_seq(-1, 1'b0, 1'b0, s);

        // Re-run after completion, with an ignored init_req during entry 2.
        pulse_init();
        run_seq(-1, 1'b1, 1'b1, s);

        // Writer never answers entry 3: timeout path.
        pulse_init();
        run_seq(3, 1'b1, 1'b0, s);
        fc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (fault === 1'b1) begin
                fc = cyc;
                break;
            end
        end
        check("fault_cycle", 64'(fc), 64'(s + TMO + 1));
        check("busy_on_fault", 64'(busy), 64'(0));
        check("reg_idx_on_fault", 64'(reg_idx), 64'(3));
        check("init_done_on_fault", 64'(init_done), 64'(0));

        // Restart from fault, then reset during WAIT_DONE of entry 5.
        pulse_init();
        run_seq(5, 1'b1, 1'b0, s);
        repeat (3) @(negedge Clk);
        check("queue_empty_before_reset", 64'(exp_q.size()), 64'(0));
        Reset = 1'b1;
        #1;
        check("midrst_start", 64'(i2c_start), 64'(0));
        check("midrst_fields", 64'({i2c_addr, i2c_data1, i2c_data2, reg_idx}), 64'(0));
        check("midrst_flags", 64'({busy, init_done, fault}), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            seen = seen | i2c_start;
        end
        check("no_start_after_reset", 64'(seen), 64'(0));
        check("idle_busy_after_reset", 64'(busy), 64'(0));

        pulse_init();
        run_seq(-1, 1'b1, 1'b0, s);

        repeat (5) @(negedge Clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
